// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, selectable overlap mode,
// a valid-qualified input stream and a saturating match counter.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap_en,
    input  logic             in_valid,
    input  logic             sequence_in,
    input  logic             clear_count,
    output logic             detector_out,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic              ovl_q,  ovl_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              det_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              sat_d;

    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              accept;
    logic              hit;

    // State register: every output is a flop, so no input reaches an output combinationally.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_q        <= '0;
            ovl_q        <= 1'b1;
            hist_q       <= '0;
            fill_q       <= '0;
            detector_out <= 1'b0;
            match_count  <= '0;
            count_sat    <= 1'b0;
        end else begin
            pat_q        <= pat_d;
            ovl_q        <= ovl_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            detector_out <= det_d;
            match_count  <= cnt_d;
            count_sat    <= sat_d;
        end
    end

    // Match evaluation on the candidate history that includes the incoming bit.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], sequence_in};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        accept     = in_valid && !cfg_load;
        hit        = accept && (fill_inc == FILL_FULL) && (hist_shift == pat_q);
    end

    // Next-state for configuration and bit history.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            pat_d  = pattern;
            ovl_d  = overlap_en;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            // Non-overlap mode forces a full fresh window after each match.
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
        end
    end

    // Output next-values: match pulse and saturating counter; clear beats a same-cycle hit.
    always_comb begin
        det_d = hit;
        cnt_d = match_count;
        sat_d = count_sat;
        if (clear_count) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit && (match_count != CNT_MAX)) begin
            cnt_d = match_count + 1'b1;
            if (cnt_d == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

endmodule
